// File: rtl/base_rr_arb_if.sv
// ---------------------------------------------------------------------------
// base_rr_arb_if : requester-side and downstream-side signals of base_rr_arb.
//
// Bundles every stream signal of the arbiter; clk and reset stay plain ports.
//   i_v [0:ways-1]        requester valid, bit k = requester k
//   i_d [0:ways*width-1]  requester data, slice k = [k*width +: width]
//   i_r [0:ways-1]        requester ready (one-hot or zero)
//   i_e [0:ways-1]        requester end-of-packet  (BASE_RR_ARB_PKT_EN only)
//   o_v                   output valid
//   o_d [0:width-1]       output data
//   o_s [0:sw-1]          index of the requester that supplied o_d
//   o_e                   registered end-of-packet (BASE_RR_ARB_PKT_EN only)
//   o_r                   downstream ready
//
// Handshake: a beat moves across any valid/ready pair on a rising clock edge
// where valid and ready are both 1. A producer holds valid and data stable
// until that happens; ready may depend combinationally on valid.
//
// Modports: slave = the arbiter, master = whoever drives the requesters and
// consumes the output (the testbench).
// Optional feature macro: BASE_RR_ARB_PKT_EN (adds i_e / o_e).
// ---------------------------------------------------------------------------
interface base_rr_arb_if #(
   parameter int ways  = 4,
   parameter int width = 8,
   parameter int sw    = $clog2(ways)
);
   logic [0:ways-1]       i_v;
   logic [0:ways*width-1] i_d;
   logic [0:ways-1]       i_r;
   logic                  o_v;
   logic [0:width-1]      o_d;
   logic [0:sw-1]         o_s;
   logic                  o_r;
`ifdef BASE_RR_ARB_PKT_EN
   logic [0:ways-1]       i_e;
   logic                  o_e;

   modport slave (
      input  i_v, i_d, i_e, o_r,
      output i_r, o_v, o_d, o_s, o_e
   );
   modport master (
      output i_v, i_d, i_e, o_r,
      input  i_r, o_v, o_d, o_s, o_e
   );
`else
   modport slave (
      input  i_v, i_d, o_r,
      output i_r, o_v, o_d, o_s
   );
   modport master (
      output i_v, i_d, o_r,
      input  i_r, o_v, o_d, o_s
   );
`endif
endinterface

// File: rtl/base_rr_arb.sv
// ---------------------------------------------------------------------------
// base_rr_arb : round-robin arbiter feeding one registered valid/ready stage.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    base_rr_arb_if.slave (requester streams in, shared stream out)
//
// The winner is the first valid requester scanning from ptr upward with
// wrap-around. Its data and index are loaded into the output register
// whenever that register is empty or being drained (en = o_r | ~o_v), so the
// stage sustains one beat per cycle. ptr moves to winner+1 after each beat.
//
// Optional feature macro: BASE_RR_ARB_PKT_EN
//   Packet-locked arbitration: a beat with i_e=0 locks the grant to its
//   requester until that requester sends a beat with i_e=1. ptr only moves
//   when a packet ends. o_e carries the end-of-packet flag of the output beat.
// No FSM; the arbitration state is ptr (plus lock/lk with the macro).
// ---------------------------------------------------------------------------
module base_rr_arb #(
   parameter int ways  = 4,
   parameter int width = 8,
   parameter int sw    = $clog2(ways)
) (
   input logic       clk,
   input logic       reset,
   base_rr_arb_if.slave bus
);

   // (a + b) mod ways, for a < ways and b < ways.
   function automatic logic [sw-1:0] wrap_add(input logic [sw-1:0] a, input int b);
      int s;
      s = int'(a) + b;
      if (s >= ways) s = s - ways;
      return sw'(s);
   endfunction

   logic             o_v_q;
   logic [0:width-1] o_d_q;
   logic [sw-1:0]    o_s_q;
   logic [sw-1:0]    ptr_q;

   logic             en;
   logic             any;
   logic [sw-1:0]    g;
   logic             xfer;
   logic [sw-1:0]    ptr_nxt;

`ifdef BASE_RR_ARB_PKT_EN
   logic             lock_q;
   logic [sw-1:0]    lk_q;
   logic             o_e_q;
`endif

   assign en = bus.o_r | ~o_v_q;

   // Winner search: first valid requester at or after ptr, wrapping.
   always_comb begin
      any = 1'b0;
      g   = '0;
      for (int j = 0; j < ways; j++) begin
         if (!any && bus.i_v[int'(wrap_add(ptr_q, j))]) begin
            any = 1'b1;
            g   = wrap_add(ptr_q, j);
         end
      end
`ifdef BASE_RR_ARB_PKT_EN
      // Mid-packet only the locked requester may be granted, even if it has
      // nothing to send this cycle.
      if (lock_q) begin
         any = bus.i_v[int'(lk_q)];
         g   = lk_q;
      end
`endif
   end

   // xfer stays free of reset so reset is only ever an async flop reset;
   // the flops it steers are held in reset anyway.
   assign xfer    = any & en;
   assign ptr_nxt = wrap_add(g, 1);

   always_comb begin
      bus.i_r = '0;
      if (xfer && !reset) bus.i_r[int'(g)] = 1'b1;
   end

   // Control state: valid flag, pointer, packet lock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_v_q  <= 1'b0;
         ptr_q  <= '0;
`ifdef BASE_RR_ARB_PKT_EN
         lock_q <= 1'b0;
         lk_q   <= '0;
         o_e_q  <= 1'b0;
`endif
      end else begin
         // en=1 either loads a new beat or drains; en=0 holds.
         if (en) o_v_q <= xfer;
         if (xfer) begin
`ifdef BASE_RR_ARB_PKT_EN
            o_e_q <= bus.i_e[int'(g)];
            if (!bus.i_e[int'(g)]) begin
               lock_q <= 1'b1;
               lk_q   <= g;
            end else begin
               // While locked g equals lk, so g+1 is lk+1.
               lock_q <= 1'b0;
               ptr_q  <= ptr_nxt;
            end
`else
            ptr_q <= ptr_nxt;
`endif
         end
      end
   end

   // Payload register: no reset, only meaningful while o_v is set.
   always_ff @(posedge clk) begin
      if (xfer) begin
         o_d_q <= bus.i_d[int'(g)*width +: width];
         o_s_q <= g;
      end
   end

   assign bus.o_v = o_v_q;
   assign bus.o_d = o_d_q;
   assign bus.o_s = o_s_q;
`ifdef BASE_RR_ARB_PKT_EN
   assign bus.o_e = o_e_q;
`endif

endmodule

// File: tb/tb_base_rr_arb.sv
// ---------------------------------------------------------------------------
// tb_base_rr_arb : directed testbench for base_rr_arb (ways=4, width=8).
// Inputs change and outputs are sampled 1 time unit after the falling edge.
// Vectors use the [0:3] bit order of the ports: 4'b1000 is requester 0.
// ---------------------------------------------------------------------------
module tb_base_rr_arb;

   localparam int WAYS  = 4;
   localparam int WIDTH = 8;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   base_rr_arb_if #(.ways(WAYS), .width(WIDTH)) bus ();

   base_rr_arb #(.ways(WAYS), .width(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #20000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock: across the rising edge to just after the falling edge.
   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      errors = 0;
      checks = 0;
      reset  = 1'b1;
      bus.o_r = 1'b1;
      bus.i_v = 4'b1111;
      bus.i_d = 32'hA0A1A2A3;
`ifdef BASE_RR_ARB_PKT_EN
      bus.i_e = 4'b1111;
`endif

      // Reset: nothing granted, output empty.
      @(negedge clk);
      #1;
      chk("rst_o_v", 32'(bus.o_v), 32'd0);
      chk("rst_i_r", 32'(bus.i_r), 32'h0);
      next_cycle();
      reset = 1'b0;
      #1;
      chk("post_rst_i_r", 32'(bus.i_r), 32'(4'b1000));
      chk("post_rst_o_v", 32'(bus.o_v), 32'd0);

      // Round-robin with all requesters valid: 0,1,2,3,0 back to back.
      for (int k = 0; k < 5; k++) begin
         next_cycle();
         chk("rr_o_v", 32'(bus.o_v), 32'd1);
         chk("rr_o_s", 32'(bus.o_s), 32'(k % 4));
         chk("rr_o_d", 32'(bus.o_d), 32'(8'hA0 + (k % 4)));
         chk("rr_i_r", 32'(bus.i_r), 32'(4'b1000 >> ((k + 1) % 4)));
      end

      // Two more beats: 1 then 2; output now shows 2, ptr=3.
      next_cycle();
      next_cycle();

      // Backpressure for 3 cycles: output holds, nobody is ready.
      bus.o_r = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("bp_o_v", 32'(bus.o_v), 32'd1);
         chk("bp_o_s", 32'(bus.o_s), 32'd2);
         chk("bp_o_d", 32'(bus.o_d), 32'hA2);
         chk("bp_i_r", 32'(bus.i_r), 32'h0);
         next_cycle();
      end

      // Release with requesters 0 and 3: ptr=3 picks 3.
      bus.o_r = 1'b1;
      bus.i_v = 4'b1001;
      #1;
      chk("bp_rel_i_r", 32'(bus.i_r), 32'(4'b0001));
      next_cycle();
      chk("bp_rel_o_s", 32'(bus.o_s), 32'd3);
      chk("bp_rel_o_d", 32'(bus.o_d), 32'hA3);
      chk("wrap_i_r", 32'(bus.i_r), 32'(4'b1000));   // ptr wrapped to 0

      // Lone requester 2 moves ptr to 3.
      bus.i_v = 4'b0010;
      next_cycle();
      chk("solo2_o_s", 32'(bus.o_s), 32'd2);
      // Sparse: only requester 1 with ptr=3.
      bus.i_v = 4'b0100;
      #1;
      chk("sparse_i_r", 32'(bus.i_r), 32'(4'b0100));
      next_cycle();
      chk("sparse_o_s", 32'(bus.o_s), 32'd1);
      chk("sparse_o_d", 32'(bus.o_d), 32'hA1);
      // All valid now: ptr=2 must pick requester 2.
      bus.i_v = 4'b1111;
      #1;
      chk("sparse_ptr", 32'(bus.i_r), 32'(4'b0010));

      // Drain: no requesters, output empties.
      bus.i_v = 4'b0000;
      #1;
      next_cycle();
      chk("drain_o_v", 32'(bus.o_v), 32'd0);
      chk("drain_i_r", 32'(bus.i_r), 32'h0);

`ifdef BASE_RR_ARB_PKT_EN
      // Packet of 3 beats from requester 2 while requester 0 waits (ptr=2).
      bus.i_v = 4'b1010;
      bus.i_e = 4'b0000;
      #1;
      chk("pkt_b1_i_r", 32'(bus.i_r), 32'(4'b0010));
      next_cycle();
      chk("pkt_b1_o_s", 32'(bus.o_s), 32'd2);
      chk("pkt_b1_o_e", 32'(bus.o_e), 32'd0);
      // Locked: requester 2 idle, requester 0 still not granted.
      bus.i_v = 4'b1000;
      #1;
      chk("pkt_lock_i_r", 32'(bus.i_r), 32'h0);
      bus.i_v = 4'b1010;
      #1;
      chk("pkt_b2_i_r", 32'(bus.i_r), 32'(4'b0010));
      next_cycle();
      chk("pkt_b2_o_s", 32'(bus.o_s), 32'd2);
      chk("pkt_b2_o_e", 32'(bus.o_e), 32'd0);
      bus.i_e = 4'b0010;
      next_cycle();
      chk("pkt_b3_o_s", 32'(bus.o_s), 32'd2);
      chk("pkt_b3_o_e", 32'(bus.o_e), 32'd1);
      // Unlocked, ptr=3: of {0,2} requester 0 wins.
      bus.i_e = 4'b1000;
      #1;
      chk("pkt_after_i_r", 32'(bus.i_r), 32'(4'b1000));
      next_cycle();
      chk("pkt_after_o_s", 32'(bus.o_s), 32'd0);
      chk("pkt_after_o_e", 32'(bus.o_e), 32'd1);

      // Mid-packet reset: requester 1 starts a packet, then reset.
      bus.i_v = 4'b0100;
      bus.i_e = 4'b0000;
      next_cycle();
      chk("mid_b1_o_s", 32'(bus.o_s), 32'd1);
      reset = 1'b1;
      #1;
      chk("mid_rst_o_v", 32'(bus.o_v), 32'd0);
      chk("mid_rst_o_e", 32'(bus.o_e), 32'd0);
      chk("mid_rst_i_r", 32'(bus.i_r), 32'h0);
      next_cycle();
      reset = 1'b0;
      bus.i_v = 4'b1111;
      #1;
      // Lock cleared and ptr back at 0.
      chk("mid_rel_i_r", 32'(bus.i_r), 32'(4'b1000));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
